// File: rtl/memory_unit.sv
// memory_unit: word-addressed memory with a program loader front end.
// After reset the whole array is zeroed (CLEAR), then the unit waits (IDLE)
// for a loader burst (LOAD), pulses execute and hands the array to the CPU
// port (RUN) until the CPU reports halted.
module memory_unit #(
    parameter int WORD_SIZE     = 16,
    parameter int MEM_ADDR_SIZE = 8,
    parameter int MEM_DEPTH     = 256
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [MEM_ADDR_SIZE-1:0] mem_address,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic [WORD_SIZE-1:0]     mem_write_data,
    output logic [WORD_SIZE-1:0]     mem_read_data,
    input  logic                     load_start,
    input  logic                     load_valid,
    input  logic [WORD_SIZE-1:0]     load_data,
    input  logic                     load_last,
    output logic                     load_ready,
    input  logic                     halted,
    output logic                     execute,
    output logic                     busy,
    output logic [1:0]               state
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    // Index width of the implemented array; the address port may be wider.
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [MEM_ADDR_SIZE-1:0] LAST_ADDR  = MEM_ADDR_SIZE'(MEM_DEPTH - 1);
    localparam logic [MEM_ADDR_SIZE:0]   ADDR_LIMIT = (MEM_ADDR_SIZE + 1)'(MEM_DEPTH);

    state_t                   state_reg, state_next;
    logic [MEM_ADDR_SIZE-1:0] clear_cnt_reg, clear_cnt_next;
    logic [MEM_ADDR_SIZE-1:0] load_ptr_reg, load_ptr_next;
    logic                     execute_reg;

    logic [WORD_SIZE-1:0]     mem [0:MEM_DEPTH-1];

    logic                     wr_en;
    logic [MEM_ADDR_SIZE-1:0] wr_addr;
    logic [WORD_SIZE-1:0]     wr_data;
    logic                     cpu_in_range;

    // Addresses at or beyond MEM_DEPTH are not backed by storage.
    assign cpu_in_range = ({1'b0, mem_address} < ADDR_LIMIT);

    // Next-state logic and the single write port shared by clear, loader and CPU.
    always_comb begin
        state_next     = state_reg;
        clear_cnt_next = clear_cnt_reg;
        load_ptr_next  = load_ptr_reg;
        wr_en          = 1'b0;
        wr_addr        = '0;
        wr_data        = '0;
        case (state_reg)
            ST_CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = clear_cnt_reg;
                if (clear_cnt_reg == LAST_ADDR) begin
                    clear_cnt_next = '0;
                    state_next     = ST_IDLE;
                end else begin
                    clear_cnt_next = clear_cnt_reg + 1'b1;
                end
            end
            ST_IDLE: begin
                if (load_start) begin
                    load_ptr_next = '0;
                    state_next    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (load_valid) begin
                    wr_en   = 1'b1;
                    wr_addr = load_ptr_reg;
                    wr_data = load_data;
                    // A full array ends the load even without load_last, so the
                    // pointer never wraps onto already-loaded words.
                    if (load_last || (load_ptr_reg == LAST_ADDR)) begin
                        state_next = ST_RUN;
                    end else begin
                        load_ptr_next = load_ptr_reg + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (mem_write && cpu_in_range) begin
                    wr_en   = 1'b1;
                    wr_addr = mem_address;
                    wr_data = mem_write_data;
                end
                if (halted) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_CLEAR;
        endcase
    end

    // State, counters and the one-cycle execute pulse on entry to RUN.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= ST_CLEAR;
            clear_cnt_reg <= '0;
            load_ptr_reg  <= '0;
            execute_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            clear_cnt_reg <= clear_cnt_next;
            load_ptr_reg  <= load_ptr_next;
            execute_reg   <= (state_next == ST_RUN) && (state_reg != ST_RUN);
        end
    end

    // Storage write; nothing is written while reset is held.
    always_ff @(posedge clock) begin
        if (wr_en && !reset) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    // Outputs are forced to their reset values in the reset cycle itself.
    assign state         = state_reg;
    assign load_ready    = (state_reg == ST_LOAD) && !reset;
    assign busy          = reset || (state_reg == ST_CLEAR) || (state_reg == ST_LOAD);
    assign execute       = execute_reg && !reset;
    // Asynchronous read: a same-cycle write is not visible until the next cycle.
    assign mem_read_data = (!reset && (state_reg == ST_RUN) && mem_read && cpu_in_range)
                           ? mem[mem_address[IDX_W-1:0]] : '0;

endmodule

// File: tb/tb_memory_unit.sv
// tb_memory_unit: directed vectors on two instances (default depth and
// depth 16); expectations are queued by the stimulus and checked by a
// negedge monitor.
module tb_memory_unit;

    localparam int SEL_ST = 0, SEL_BUSY = 1, SEL_EXEC = 2, SEL_RDY = 3, SEL_RD = 4;

    typedef struct {
        int          dut;
        int          sel;
        logic [15:0] exp;
        string       name;
    } chk_t;

    logic        clk;
    logic        rst    [2];
    logic [7:0]  addr   [2];
    logic        rd     [2];
    logic        wr     [2];
    logic [15:0] wdata  [2];
    logic        lstart [2];
    logic        lvalid [2];
    logic [15:0] ldata  [2];
    logic        llast  [2];
    logic        halt   [2];

    logic [15:0] rdata0, rdata1;
    logic        lready0, lready1, exec0, exec1, busy0, busy1;
    logic [1:0]  st0, st1;

    chk_t        sb[$];
    chk_t        cur;
    logic [15:0] got;
    int          n_checks = 0;
    int          n_fail   = 0;

    memory_unit #(.WORD_SIZE(16), .MEM_ADDR_SIZE(8), .MEM_DEPTH(256)) dut0 (
        .clock(clk), .reset(rst[0]), .mem_address(addr[0]), .mem_read(rd[0]),
        .mem_write(wr[0]), .mem_write_data(wdata[0]), .mem_read_data(rdata0),
        .load_start(lstart[0]), .load_valid(lvalid[0]), .load_data(ldata[0]),
        .load_last(llast[0]), .load_ready(lready0), .halted(halt[0]),
        .execute(exec0), .busy(busy0), .state(st0)
    );

    memory_unit #(.WORD_SIZE(16), .MEM_ADDR_SIZE(8), .MEM_DEPTH(16)) dut1 (
        .clock(clk), .reset(rst[1]), .mem_address(addr[1]), .mem_read(rd[1]),
        .mem_write(wr[1]), .mem_write_data(wdata[1]), .mem_read_data(rdata1),
        .load_start(lstart[1]), .load_valid(lvalid[1]), .load_data(ldata[1]),
        .load_last(llast[1]), .load_ready(lready1), .halted(halt[1]),
        .execute(exec1), .busy(busy1), .state(st1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] get_sig(int d, int sel);
        logic [15:0] v;
        v = '0;
        case (sel)
            SEL_ST:   v = (d == 0) ? {14'b0, st0} : {14'b0, st1};
            SEL_BUSY: v = (d == 0) ? {15'b0, busy0} : {15'b0, busy1};
            SEL_EXEC: v = (d == 0) ? {15'b0, exec0} : {15'b0, exec1};
            SEL_RDY:  v = (d == 0) ? {15'b0, lready0} : {15'b0, lready1};
            default:  v = (d == 0) ? rdata0 : rdata1;
        endcase
        return v;
    endfunction

    // Monitor: compare every expectation queued for the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            got = get_sig(cur.dut, cur.sel);
            n_checks++;
            if (got !== cur.exp) begin
                n_fail++;
                $display("FAIL dut%0d %s: got %h, want %h", cur.dut, cur.name, got, cur.exp);
            end else begin
                $display("ok   dut%0d %s: %h", cur.dut, cur.name, got);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_sig(int d, int sel, logic [15:0] v, string n);
        chk_t c;
        c.dut = d; c.sel = sel; c.exp = v; c.name = n;
        sb.push_back(c);
    endtask

    task automatic reset_and_clear(int d, int depth, string tag);
        rst[d] = 1'b1;
        expect_sig(d, SEL_BUSY, 16'd1, {tag, " busy in reset"});
        expect_sig(d, SEL_RDY,  16'd0, {tag, " load_ready in reset"});
        expect_sig(d, SEL_EXEC, 16'd0, {tag, " execute in reset"});
        tick();
        rd[d] = 1'b1; addr[d] = 8'd0;
        expect_sig(d, SEL_ST,   16'd0, {tag, " state after reset"});
        expect_sig(d, SEL_RD,   16'd0, {tag, " read data in reset"});
        tick();
        rst[d] = 1'b0; rd[d] = 1'b0;
        for (int i = 0; i < depth; i++) begin
            if (i == 0 || i == depth - 1) begin
                expect_sig(d, SEL_ST,   16'd0, {tag, " clear state"});
                expect_sig(d, SEL_BUSY, 16'd1, {tag, " clear busy"});
            end
            tick();
        end
        expect_sig(d, SEL_ST,   16'd1, {tag, " idle after clear"});
        expect_sig(d, SEL_BUSY, 16'd0, {tag, " busy idle"});
        expect_sig(d, SEL_RDY,  16'd0, {tag, " load_ready idle"});
    endtask

    task automatic start_load(int d);
        lstart[d] = 1'b1;
        tick();
        lstart[d] = 1'b0;
        expect_sig(d, SEL_ST,   16'd2, "state load");
        expect_sig(d, SEL_RDY,  16'd1, "load_ready load");
        expect_sig(d, SEL_BUSY, 16'd1, "busy load");
    endtask

    task automatic read_chk(int d, logic [7:0] a, logic [15:0] v, string n);
        rd[d] = 1'b1; addr[d] = a;
        expect_sig(d, SEL_RD, v, n);
        tick();
        rd[d] = 1'b0;
    endtask

    initial begin
        logic [15:0] words [3];
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; addr[d] = '0; rd[d] = 1'b0; wr[d] = 1'b0; wdata[d] = '0;
            lstart[d] = 1'b0; lvalid[d] = 1'b0; ldata[d] = '0; llast[d] = 1'b0; halt[d] = 1'b0;
        end
        tick();

        // ---- instance 0: depth 256 ----
        reset_and_clear(0, 256, "d256");
        // Loader word while idle is ignored.
        lvalid[0] = 1'b1; ldata[0] = 16'hDEAD; llast[0] = 1'b1;
        tick();
        lvalid[0] = 1'b0; llast[0] = 1'b0;
        expect_sig(0, SEL_ST,   16'd1, "idle ignores load_valid");
        expect_sig(0, SEL_EXEC, 16'd0, "no execute in idle");
        start_load(0);
        for (int k = 0; k < 6; k++) begin
            lvalid[0] = k[0]; ldata[0] = words[k / 2]; llast[0] = (k == 5);
            if (k == 4) expect_sig(0, SEL_ST, 16'd2, "still loading");
            tick();
        end
        lvalid[0] = 1'b0; llast[0] = 1'b0;
        expect_sig(0, SEL_ST,   16'd3, "run after last");
        expect_sig(0, SEL_EXEC, 16'd1, "execute pulse");
        expect_sig(0, SEL_BUSY, 16'd0, "busy run");
        expect_sig(0, SEL_RDY,  16'd0, "load_ready run");
        tick();
        expect_sig(0, SEL_EXEC, 16'd0, "execute one cycle");
        read_chk(0, 8'd0,   16'h1111, "rd addr0");
        read_chk(0, 8'd1,   16'h2222, "rd addr1");
        read_chk(0, 8'd2,   16'h3333, "rd addr2");
        read_chk(0, 8'd3,   16'h0000, "rd addr3 cleared");
        read_chk(0, 8'd255, 16'h0000, "rd addr255 cleared");
        rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 8'd5; wdata[0] = 16'hBEEF;
        expect_sig(0, SEL_RD, 16'h0000, "rd-during-wr old value");
        tick();
        wr[0] = 1'b0;
        expect_sig(0, SEL_RD, 16'hBEEF, "rd after wr");
        tick();
        rd[0] = 1'b0;
        expect_sig(0, SEL_RD, 16'h0000, "no mem_read gives 0");
        tick();
        halt[0] = 1'b1;
        expect_sig(0, SEL_ST, 16'd3, "run before halt edge");
        tick();
        halt[0] = 1'b0;
        expect_sig(0, SEL_ST, 16'd1, "idle after halt");
        rd[0] = 1'b1; addr[0] = 8'd5;
        expect_sig(0, SEL_RD, 16'h0000, "read ignored in idle");
        wr[0] = 1'b1; wdata[0] = 16'h9999; addr[0] = 8'd1;
        tick();
        rd[0] = 1'b0; wr[0] = 1'b0;
        start_load(0);
        lvalid[0] = 1'b1; ldata[0] = 16'hAAAA; llast[0] = 1'b1;
        tick();
        lvalid[0] = 1'b0; llast[0] = 1'b0;
        expect_sig(0, SEL_ST,   16'd3, "run after 1-word load");
        expect_sig(0, SEL_EXEC, 16'd1, "execute second load");
        tick();
        read_chk(0, 8'd0, 16'hAAAA, "reload addr0");
        read_chk(0, 8'd1, 16'h2222, "addr1 kept");
        read_chk(0, 8'd2, 16'h3333, "addr2 kept");
        read_chk(0, 8'd5, 16'hBEEF, "addr5 kept");
        // Reset in the middle of a load.
        halt[0] = 1'b1;
        tick();
        halt[0] = 1'b0;
        start_load(0);
        lvalid[0] = 1'b1; ldata[0] = 16'h5555;
        tick();
        ldata[0] = 16'h6666;
        tick();
        lvalid[0] = 1'b0;
        expect_sig(0, SEL_ST, 16'd2, "mid-load before reset");
        reset_and_clear(0, 256, "d256 reclear");
        start_load(0);
        lvalid[0] = 1'b1; ldata[0] = 16'h0000; llast[0] = 1'b1;
        tick();
        lvalid[0] = 1'b0; llast[0] = 1'b0;
        expect_sig(0, SEL_ST, 16'd3, "run after reclear");
        tick();
        read_chk(0, 8'd1, 16'h0000, "addr1 reclear");
        read_chk(0, 8'd2, 16'h0000, "addr2 reclear");
        read_chk(0, 8'd5, 16'h0000, "addr5 reclear");

        // ---- instance 1: depth 16, load fills the array ----
        reset_and_clear(1, 16, "d16");
        start_load(1);
        for (int i = 0; i < 16; i++) begin
            lvalid[1] = 1'b1; ldata[1] = 16'(16'h1000 + i);
            if (i == 15) expect_sig(1, SEL_ST, 16'd2, "load before 16th");
            tick();
        end
        ldata[1] = 16'hFFFF;
        expect_sig(1, SEL_ST,   16'd3, "run after full");
        expect_sig(1, SEL_RDY,  16'd0, "load_ready after full");
        expect_sig(1, SEL_EXEC, 16'd1, "execute after full");
        tick();
        lvalid[1] = 1'b0;
        rd[1] = 1'b1; wr[1] = 1'b1; addr[1] = 8'd20; wdata[1] = 16'hCAFE;
        expect_sig(1, SEL_RD, 16'h0000, "rd addr20 during wr");
        tick();
        wr[1] = 1'b0;
        expect_sig(1, SEL_RD, 16'h0000, "rd addr20 after wr");
        tick();
        read_chk(1, 8'd4,  16'h1004, "addr4 not aliased");
        read_chk(1, 8'd15, 16'h100F, "addr15");
        read_chk(1, 8'd0,  16'h1000, "addr0 no wrap");

        @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: got %0d pending, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
